cdb_arbiter: RTL and testbench

Arbitrates completion results from NUM_FU functional units onto the single common data bus (CDB) that drives the ROB completion inputs (execution_finished, executed_rob_entry, cdb_mis_pred) and PRF/RS wakeup. Each FU owns a one-entry holding buffer. A round-robin arbiter grants one buffered result per cycle, and the grant is broadcast from a registered output stage. A ROB squash flushes every buffered and in-flight result.

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_arbiter_rr_arbiter.sv | 32 +++
 rtl/cdb_arbiter.sv | 85 ++++++++
 tb/tb_cdb_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the completion path: widths and the CDB broadcast packet
// reused by the ROB, RS and PRF.
package cdb_arbiter_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ROB_LEN = 5;
   localparam int unsigned PRF_LEN = 6;

   typedef struct packed {
      logic [ROB_LEN-1:0] rob_entry;
      logic [PRF_LEN-1:0] dest_preg;
      logic [XLEN-1:0]    value;
      logic               mis_pred;
   } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first set request at or above ptr,
// scanning modulo N. Also reused for RS issue selection.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx,
   output logic          any_grant
);

   always_comb begin
      int unsigned idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         // Explicit wrap keeps non-power-of-2 N correct.
         idx = 32'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!any_grant && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
            any_grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-FU one-entry holding buffers, round-robin selection onto the CDB and
// a registered broadcast stage; squash flushes everything but the pointer.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_FU = 4,
   parameter int unsigned RR_LEN = $clog2(NUM_FU)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             squash,
   input  logic [NUM_FU-1:0]                fu_valid,
   input  logic [NUM_FU-1:0][ROB_LEN-1:0]   fu_rob_entry,
   input  logic [NUM_FU-1:0][PRF_LEN-1:0]   fu_dest_preg,
   input  logic [NUM_FU-1:0][XLEN-1:0]      fu_value,
   input  logic [NUM_FU-1:0]                fu_mis_pred,
   output logic [NUM_FU-1:0]                fu_ready,
   output logic                             cdb_valid,
   output logic [ROB_LEN-1:0]               cdb_rob_entry,
   output logic [PRF_LEN-1:0]               cdb_dest_preg,
   output logic [XLEN-1:0]                  cdb_value,
   output logic                             cdb_mis_pred
);

   logic [NUM_FU-1:0] r_held;
   cdb_packet_t       r_buf [NUM_FU];
   logic [RR_LEN-1:0] r_rr_ptr;
   logic              r_cdb_valid;
   cdb_packet_t       r_cdb_pkt;

   logic [NUM_FU-1:0] w_grant;
   logic [RR_LEN-1:0] w_grant_idx;
   logic              w_any_grant;
   logic [NUM_FU-1:0] w_fu_ready;

   rr_arbiter #(
      .N  (NUM_FU),
      .PW (RR_LEN)
   ) u_rr (
      .req       (r_held),
      .ptr       (r_rr_ptr),
      .grant     (w_grant),
      .grant_idx (w_grant_idx),
      .any_grant (w_any_grant)
   );

   assign w_fu_ready = {NUM_FU{!squash}} & (~r_held | w_grant);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_held      <= '0;
         r_rr_ptr    <= '0;
         r_cdb_valid <= 1'b0;
         r_cdb_pkt   <= '0;
         for (int unsigned i = 0; i < NUM_FU; i++) r_buf[i] <= '0;
      end else if (squash) begin
         r_held      <= '0;
         r_cdb_valid <= 1'b0;
      end else begin
         r_cdb_valid <= w_any_grant;
         if (w_any_grant) begin
            r_cdb_pkt            <= r_buf[w_grant_idx];
            r_held[w_grant_idx]  <= 1'b0;
            r_rr_ptr             <= (w_grant_idx == RR_LEN'(NUM_FU-1)) ? '0
                                    : w_grant_idx + 1'b1;
         end
         // Accepts come after the grant clear so a same-cycle refill keeps held set.
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && w_fu_ready[i]) begin
               r_buf[i]  <= '{rob_entry: fu_rob_entry[i], dest_preg: fu_dest_preg[i],
                              value: fu_value[i], mis_pred: fu_mis_pred[i]};
               r_held[i] <= 1'b1;
            end
         end
      end
   end

   assign fu_ready      = w_fu_ready;
   assign cdb_valid     = r_cdb_valid;
   assign cdb_rob_entry = r_cdb_pkt.rob_entry;
   assign cdb_dest_preg = r_cdb_pkt.dest_preg;
   assign cdb_value     = r_cdb_pkt.value;
   assign cdb_mis_pred  = r_cdb_pkt.mis_pred;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a per-FU slot model pushes expected
// broadcasts at each edge, a negedge monitor pops and compares them.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int unsigned N = 4;

   logic                        clock = 1'b0;
   logic                        reset, squash;
   logic [N-1:0]                fu_valid, fu_mis_pred, fu_ready;
   logic [N-1:0][ROB_LEN-1:0]   fu_rob_entry;
   logic [N-1:0][PRF_LEN-1:0]   fu_dest_preg;
   logic [N-1:0][XLEN-1:0]      fu_value;
   logic                        cdb_valid, cdb_mis_pred;
   logic [ROB_LEN-1:0]          cdb_rob_entry;
   logic [PRF_LEN-1:0]          cdb_dest_preg;
   logic [XLEN-1:0]             cdb_value;

   always #5 clock = ~clock;

   cdb_arbiter #(.NUM_FU(N)) dut (
      .clock(clock), .reset(reset), .squash(squash),
      .fu_valid(fu_valid), .fu_rob_entry(fu_rob_entry), .fu_dest_preg(fu_dest_preg),
      .fu_value(fu_value), .fu_mis_pred(fu_mis_pred), .fu_ready(fu_ready),
      .cdb_valid(cdb_valid), .cdb_rob_entry(cdb_rob_entry), .cdb_dest_preg(cdb_dest_preg),
      .cdb_value(cdb_value), .cdb_mis_pred(cdb_mis_pred)
   );

   // Reference model: which FUs hold a result, what they hold, whose turn it is.
   bit          m_held [N];
   cdb_packet_t m_pkt  [N];
   int          m_ptr;
   cdb_packet_t exp_q  [$];
   bit          m_live = 1'b0;
   bit          m_just_reset = 1'b0;
   int          total = 0;
   int          bad = 0;

   function automatic int m_winner();
      for (int k = 0; k < N; k++)
         if (m_held[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock) begin : model
      int g;
      bit ok [N];
      if (reset) begin
         for (int i = 0; i < N; i++) begin m_held[i] = 1'b0; m_pkt[i] = '0; end
         m_ptr = 0;
         exp_q.delete();
         m_live = 1'b1;
         m_just_reset = 1'b1;
      end else begin
         m_just_reset = 1'b0;
         if (m_live && squash) begin
            for (int i = 0; i < N; i++) m_held[i] = 1'b0;
         end else if (m_live) begin
            g = m_winner();
            for (int i = 0; i < N; i++) ok[i] = !m_held[i] || (g == i);
            if (g >= 0) begin
               exp_q.push_back(m_pkt[g]);
               m_held[g] = 1'b0;
               m_ptr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++)
               if (fu_valid[i] && ok[i]) begin
                  m_pkt[i] = '{rob_entry: fu_rob_entry[i], dest_preg: fu_dest_preg[i],
                               value: fu_value[i], mis_pred: fu_mis_pred[i]};
                  m_held[i] = 1'b1;
               end
         end
      end
   end

   always @(negedge clock) begin : monitor
      int g;
      logic [N-1:0] exp_rdy;
      cdb_packet_t  e;
      if (m_live) begin
         g = m_winner();
         for (int i = 0; i < N; i++) exp_rdy[i] = !squash && (!m_held[i] || g == i);
         chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));
         chk("cdb_valid", 64'(cdb_valid), 64'(exp_q.size() != 0));
         if (cdb_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("cdb_pkt", 64'({cdb_rob_entry, cdb_dest_preg, cdb_value, cdb_mis_pred}), 64'(e));
         end
         if (m_just_reset)
            chk("reset_payload", 64'({cdb_rob_entry, cdb_dest_preg, cdb_value, cdb_mis_pred}), 64'd0);
      end
   end

   task automatic present(input int i, input int rob, input int preg, input int val, input bit mp);
      fu_valid[i]     = 1'b1;
      fu_rob_entry[i] = ROB_LEN'(rob);
      fu_dest_preg[i] = PRF_LEN'(preg);
      fu_value[i]     = XLEN'(val);
      fu_mis_pred[i]  = mp;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
         fu_valid = '0;
         squash   = 1'b0;
         reset    = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; squash = 1'b0; fu_valid = '0; fu_mis_pred = '0;
      fu_rob_entry = '0; fu_dest_preg = '0; fu_value = '0;
      step(2);
      // Single request from FU1, then FU1/FU2 together: FU2 must win first.
      present(1, 3, 5, 32'hDEAD, 1'b0); step(1);
      step(3);
      present(1, 1, 11, 32'h11, 1'b0); present(2, 2, 12, 32'h22, 1'b1); step(1);
      step(4);
      // Full contention from rr_ptr=0.
      reset = 1'b1; step(1);
      for (int i = 0; i < N; i++) present(i, i, 20 + i, 32'hA000 + i, i[0]);
      step(1); step(6);
      // Fairness with rr_ptr=1: FU0 and FU2 request continuously.
      reset = 1'b1; step(1);
      present(0, 9, 1, 1, 1'b0); step(1); step(3);
      for (int c = 0; c < 10; c++) begin
         present(0, c, 2, 100 + c, 1'b0); present(2, 16 + c, 3, 200 + c, 1'b0); step(1);
      end
      step(4);
      // Refill under grant: FU3 alone, five back-to-back results.
      for (int c = 8; c <= 12; c++) begin present(3, c, 30, c, 1'b1); step(1); end
      step(4);
      // Squash while broadcasting rob_entry 7 with FUs 0-2 held.
      present(3, 7, 7, 7, 1'b0); step(1);
      for (int i = 0; i < 3; i++) present(i, 24 + i, 8, 300 + i, 1'b0);
      step(1);
      squash = 1'b1; present(3, 31, 9, 999, 1'b0); step(1);
      step(3);
      for (int i = 0; i < N; i++) present(i, 12 + i, 10, 400 + i, 1'b0);
      step(1); step(6);
      // Reset with three results pending.
      for (int i = 0; i < 3; i++) present(i, 4 + i, 11, 500 + i, 1'b1);
      step(1);
      reset = 1'b1; present(3, 1, 1, 1, 1'b0); step(1);
      step(3);
      // Randomized traffic with occasional squash and reset.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 99) < 60)
               present(i, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                       int'($urandom), bit'($urandom_range(0, 1)));
         squash = ($urandom_range(0, 39) == 0);
         reset  = ($urandom_range(0, 299) == 0);
         step(1);
      end
      step(10);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
